// File: rtl/spi_multi_handler.sv
// SPI master command handler: gathers a command payload, checks it, runs one CS-framed write/read transfer and uploads the read bytes.
// Define SPI_HANDLER_MODE_SEL_EN to take cpol/cpha from payload byte0; otherwise mode 0 is fixed.
module spi_multi_handler #(
  parameter int NUM_CS    = 4,
  parameter int CLK_DIV   = 4,
  parameter int BUF_DEPTH = 256
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        cmd_type,
  input  logic [15:0]       cmd_length,
  input  logic [7:0]        cmd_data,
  input  logic [15:0]       cmd_data_index,
  input  logic              cmd_start,
  input  logic              cmd_data_valid,
  input  logic              cmd_done,
  output logic              cmd_ready,
  output logic              spi_clk,
  output logic [NUM_CS-1:0] spi_cs_n,
  output logic              spi_mosi,
  input  logic              spi_miso,
  output logic              upload_req,
  output logic              upload_valid,
  output logic [7:0]        upload_data,
  output logic [7:0]        upload_source,
  input  logic              upload_ready,
  output logic              busy
);

  localparam int AW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;
  localparam int DW = $clog2(CLK_DIV + 1);
  localparam logic [DW-1:0]     DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0]     DIV_FULL = DW'(CLK_DIV);
  localparam logic [DW-1:0]     DIV_ONE  = DW'(1);
  localparam logic [8:0]        DEPTH9   = 9'(BUF_DEPTH);
  localparam logic [15:0]       DEPTH16  = 16'(BUF_DEPTH);
  localparam logic [NUM_CS-1:0] CS_ONE   = NUM_CS'(1);

  typedef enum logic [2:0] {IDLE, COLLECT, CHECK, CS_SETUP, SHIFT, CS_HOLD, UPLOAD} state_t;

  state_t            state_q, state_d;
  logic              rd_en_q, rd_en_d;
  logic [15:0]       len_q, len_d;
  logic [3:0]        cs_idx_q, cs_idx_d;
  logic [8:0]        wl_q, wl_d, rl_q, rl_d, bc_q, bc_d, up_cnt_q, up_cnt_d;
  logic [2:0]        bitc_q, bitc_d;
  logic [DW-1:0]     div_q, div_d;
  logic              spi_clk_q, spi_clk_d, mosi_q, mosi_d;
  logic [NUM_CS-1:0] cs_n_q, cs_n_d;
  logic [6:0]        rx_sh_q, rx_sh_d;
  logic              up_valid_q, up_valid_d;
  logic [7:0]        up_data_q, up_data_d, up_src_q, up_src_d;
  logic              cpol, cpha;

`ifdef SPI_HANDLER_MODE_SEL_EN
  logic [1:0] mode_q, mode_d;
  assign cpol = mode_q[1];
  assign cpha = mode_q[0];
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) mode_q <= 2'b00;
    else        mode_q <= mode_d;
`else
  assign cpol = 1'b0;
  assign cpha = 1'b0;
`endif

  // Buffers carry no reset; only the write pointers and lengths are trusted.
  logic [7:0]    tx_mem [BUF_DEPTH];
  logic [7:0]    rx_mem [BUF_DEPTH];
  logic          tx_we, rx_we;
  logic [15:0]   tx_widx;
  logic [8:0]    rx_widx, rl_eff, nxt_bc;
  logic [7:0]    cur_byte, nxt_byte, rx_byte;
  logic [2:0]    nxt_bitc;
  logic          lead, last_bit, reject;

  assign tx_widx  = cmd_data_index - 16'd3;
  assign rx_widx  = bc_q - wl_q;
  assign rx_byte  = {rx_sh_q, spi_miso};
  assign nxt_bc   = (bitc_q == 3'd7) ? bc_q + 9'd1 : bc_q;
  assign nxt_bitc = bitc_q + 3'd1;
  // Bytes past write_len are the read phase and shift out as zeros.
  assign cur_byte = (bc_q < wl_q)   ? tx_mem[bc_q[AW-1:0]]   : 8'h00;
  assign nxt_byte = (nxt_bc < wl_q) ? tx_mem[nxt_bc[AW-1:0]] : 8'h00;
  assign last_bit = (bc_q == wl_q + rl_q - 9'd1) && (bitc_q == 3'd7);
  assign lead     = (spi_clk_q == cpol);
  assign rl_eff   = rd_en_q ? rl_q : 9'd0;
  assign reject   = (32'(cs_idx_q) >= NUM_CS) || (wl_q + rl_eff == 9'd0) ||
                    (wl_q > DEPTH9) || (rl_eff > DEPTH9) ||
                    (17'd3 + 17'(wl_q) > 17'(len_q));

  always_ff @(posedge clk) begin
    if (tx_we) tx_mem[tx_widx[AW-1:0]] <= cmd_data;
    if (rx_we) rx_mem[rx_widx[AW-1:0]] <= rx_byte;
  end

  always_comb begin
    state_d    = state_q;
    rd_en_d    = rd_en_q;
    len_d      = len_q;
    cs_idx_d   = cs_idx_q;
    wl_d       = wl_q;
    rl_d       = rl_q;
    bc_d       = bc_q;
    bitc_d     = bitc_q;
    div_d      = div_q;
    spi_clk_d  = spi_clk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    rx_sh_d    = rx_sh_q;
    up_cnt_d   = up_cnt_q;
    up_valid_d = 1'b0;
    up_data_d  = up_data_q;
    up_src_d   = up_src_q;
    tx_we      = 1'b0;
    rx_we      = 1'b0;
`ifdef SPI_HANDLER_MODE_SEL_EN
    mode_d     = mode_q;
`endif
    case (state_q)
      IDLE: if (cmd_start && (cmd_type == 8'h11 || cmd_type == 8'h12) && cmd_length >= 16'd3) begin
        state_d  = COLLECT;
        rd_en_d  = (cmd_type == 8'h12);
        len_d    = cmd_length;
        cs_idx_d = 4'd0;
        wl_d     = 9'd0;
        rl_d     = 9'd0;
        bc_d     = 9'd0;
        bitc_d   = 3'd0;
`ifdef SPI_HANDLER_MODE_SEL_EN
        mode_d   = 2'b00;
`endif
      end
      COLLECT: begin
        if (cmd_data_valid) begin
          if (cmd_data_index == 16'd0) begin
            cs_idx_d = cmd_data[7:4];
`ifdef SPI_HANDLER_MODE_SEL_EN
            mode_d   = cmd_data[1:0];
`endif
          end
          else if (cmd_data_index == 16'd1) wl_d = {1'b0, cmd_data};
          else if (cmd_data_index == 16'd2) rl_d = {1'b0, cmd_data};
          else if (tx_widx < DEPTH16)       tx_we = 1'b1;
        end
        if (cmd_done) state_d = CHECK;
      end
      CHECK: begin
        rl_d  = rl_eff;
        div_d = '0;
        if (reject) state_d = IDLE;
        else begin
          // Park the clock at cpol before CS falls; cpha=0 needs bit 0 ready at CS assertion.
          state_d   = CS_SETUP;
          spi_clk_d = cpol;
          mosi_d    = cpha ? 1'b0 : cur_byte[~bitc_q];
        end
      end
      CS_SETUP: begin
        cs_n_d = ~(CS_ONE << cs_idx_q);
        if (div_q == DIV_FULL) begin
          div_d   = '0;
          state_d = SHIFT;
        end else div_d = div_q + DIV_ONE;
      end
      SHIFT: begin
        if (div_q == DIV_LAST) begin
          div_d     = '0;
          spi_clk_d = ~spi_clk_q;
          if (lead != cpha) begin
            rx_sh_d = {rx_sh_q[5:0], spi_miso};
            if (bitc_q == 3'd7 && bc_q >= wl_q && rx_widx < DEPTH9) rx_we = 1'b1;
          end
          // The bit pointer advances on trailing edges only.
          if (!lead) begin
            if (last_bit) state_d = CS_HOLD;
            else begin
              bc_d   = nxt_bc;
              bitc_d = nxt_bitc;
              if (!cpha) mosi_d = nxt_byte[~nxt_bitc];
            end
          end else if (cpha) mosi_d = cur_byte[~bitc_q];
        end else div_d = div_q + DIV_ONE;
      end
      CS_HOLD: begin
        if (div_q == DIV_LAST) begin
          div_d    = '0;
          cs_n_d   = '1;
          mosi_d   = 1'b0;
          up_cnt_d = 9'd0;
          state_d  = (rl_q != 9'd0) ? UPLOAD : IDLE;
        end else div_d = div_q + DIV_ONE;
      end
      UPLOAD: begin
        // Stay one extra cycle after the last issue so upload_req covers the final valid.
        if (up_cnt_q == rl_q) state_d = IDLE;
        else if (upload_ready) begin
          up_valid_d = 1'b1;
          up_data_d  = rx_mem[up_cnt_q[AW-1:0]];
          up_src_d   = 8'h03;
          up_cnt_d   = up_cnt_q + 9'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      rd_en_q    <= 1'b0;
      len_q      <= '0;
      cs_idx_q   <= '0;
      wl_q       <= '0;
      rl_q       <= '0;
      bc_q       <= '0;
      bitc_q     <= '0;
      div_q      <= '0;
      spi_clk_q  <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= '1;
      rx_sh_q    <= '0;
      up_cnt_q   <= '0;
      up_valid_q <= 1'b0;
      up_data_q  <= '0;
      up_src_q   <= '0;
    end else begin
      state_q    <= state_d;
      rd_en_q    <= rd_en_d;
      len_q      <= len_d;
      cs_idx_q   <= cs_idx_d;
      wl_q       <= wl_d;
      rl_q       <= rl_d;
      bc_q       <= bc_d;
      bitc_q     <= bitc_d;
      div_q      <= div_d;
      spi_clk_q  <= spi_clk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
      rx_sh_q    <= rx_sh_d;
      up_cnt_q   <= up_cnt_d;
      up_valid_q <= up_valid_d;
      up_data_q  <= up_data_d;
      up_src_q   <= up_src_d;
    end
  end

  assign cmd_ready     = (state_q == IDLE) || (state_q == COLLECT);
  assign busy          = (state_q != IDLE);
  assign upload_req    = (state_q == UPLOAD);
  assign upload_valid  = up_valid_q;
  assign upload_data   = up_data_q;
  assign upload_source = up_src_q;
  assign spi_clk       = spi_clk_q;
  assign spi_mosi      = mosi_q;
  assign spi_cs_n      = cs_n_q;

endmodule

// File: tb/tb_spi_multi_handler.sv
// Directed bench for spi_multi_handler: a behavioural SPI slave feeds MISO, monitors log MOSI, CS and uploads.
module tb_spi_multi_handler;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  cmd_type = 8'h00, cmd_data = 8'h00;
  logic [15:0] cmd_length = 16'd0, cmd_data_index = 16'd0;
  logic        cmd_start = 1'b0, cmd_data_valid = 1'b0, cmd_done = 1'b0;
  logic        cmd_ready, spi_clk, spi_mosi, busy;
  logic [3:0]  spi_cs_n;
  logic        spi_miso = 1'b0;
  logic        upload_req, upload_valid, upload_ready = 1'b1;
  logic [7:0]  upload_data, upload_source;

  spi_multi_handler dut (
    .clk(clk), .rst_n(rst_n), .cmd_type(cmd_type), .cmd_length(cmd_length),
    .cmd_data(cmd_data), .cmd_data_index(cmd_data_index), .cmd_start(cmd_start),
    .cmd_data_valid(cmd_data_valid), .cmd_done(cmd_done), .cmd_ready(cmd_ready),
    .spi_clk(spi_clk), .spi_cs_n(spi_cs_n), .spi_mosi(spi_mosi), .spi_miso(spi_miso),
    .upload_req(upload_req), .upload_valid(upload_valid), .upload_data(upload_data),
    .upload_source(upload_source), .upload_ready(upload_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0, failures = 0;
  logic [7:0] pl [0:15];

  // monitors: only ever accumulate; tests work from deltas
  int          pos_cnt = 0, tog_cnt = 0, cs_cyc = 0, multi_n = 0, up_n = 0;
  logic [63:0] mosi_sh = '0;
  logic [3:0]  cs_pat = 4'hF;
  logic [7:0]  up_data [0:63];
  logic [7:0]  up_src [0:63];
  logic        up_req_at [0:63];
  logic        prev_v = 1'b0, req_after = 1'b0;
  wire         cs_act = ~&spi_cs_n;

  always @(posedge spi_clk) if (cs_act === 1'b1) begin
    pos_cnt++;
    mosi_sh = {mosi_sh[62:0], spi_mosi};
  end
  always @(spi_clk) tog_cnt++;

  always @(negedge clk) if (rst_n) begin
    if ($countones(~spi_cs_n) > 1) multi_n++;
    if (spi_cs_n != 4'hF) begin cs_cyc++; cs_pat = spi_cs_n; end
    if (prev_v) req_after = upload_req;
    prev_v = upload_valid;
    if (upload_valid && up_n < 64) begin
      up_data[up_n] = upload_data;
      up_src[up_n] = upload_source;
      up_req_at[up_n] = upload_req;
      up_n++;
    end
  end

  // SPI slave: shifts sl_bytes out MSB first, changing MISO on falling spi_clk
  logic [7:0] sl_bytes [0:7];
  logic       sl_cpha = 1'b0, sl_on = 1'b0;
  int         sl_idx = 0;
  task automatic sl_drive();
    logic [7:0] b;
    b = (sl_idx < 64) ? sl_bytes[sl_idx / 8] : 8'h00;
    spi_miso = b[7 - (sl_idx % 8)];
    sl_idx++;
  endtask
  always @(cs_act or negedge spi_clk) begin
    if (cs_act !== 1'b1) sl_on = 1'b0;
    else if (!sl_on) begin
      sl_on = 1'b1;
      sl_idx = 0;
      if (!sl_cpha) sl_drive();
    end else if (spi_clk == 1'b0) sl_drive();
  end

  task automatic send_cmd(input logic [7:0] typ, input logic [15:0] len, input int n);
    @(negedge clk);
    cmd_start = 1'b1; cmd_type = typ; cmd_length = len;
    @(negedge clk);
    cmd_start = 1'b0;
    for (int i = 0; i < n; i++) begin
      cmd_data_valid = 1'b1; cmd_data = pl[i]; cmd_data_index = 16'(i);
      @(negedge clk);
    end
    cmd_data_valid = 1'b0; cmd_done = 1'b1;
    @(negedge clk);
    cmd_done = 1'b0;
  endtask

  task automatic wait_idle(input string name);
    int n = 0;
    while (busy && n < 3000) begin @(negedge clk); n++; end
    checks++;
    if (busy !== 1'b0) begin failures++; $display("FAIL %s timeout: busy=%b want 0", name, busy); end
  endtask

  task automatic test_reset();
    checks++; if (spi_cs_n !== 4'hF) begin failures++; $display("FAIL rst_cs got=%h want f", spi_cs_n); end
    checks++; if (spi_clk !== 1'b0) begin failures++; $display("FAIL rst_sclk got=%b want 0", spi_clk); end
    checks++; if (spi_mosi !== 1'b0) begin failures++; $display("FAIL rst_mosi got=%b want 0", spi_mosi); end
    checks++; if (cmd_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b want 1", cmd_ready); end
    checks++; if (busy !== 1'b0) begin failures++; $display("FAIL rst_busy got=%b want 0", busy); end
    checks++; if (upload_req !== 1'b0 || upload_valid !== 1'b0) begin failures++; $display("FAIL rst_upload req=%b vld=%b want 0 0", upload_req, upload_valid); end
    checks++; if (upload_data !== 8'h00 || upload_source !== 8'h00) begin failures++; $display("FAIL rst_updata data=%h src=%h want 00 00", upload_data, upload_source); end
  endtask

  task automatic test_write();
    int p0 = pos_cnt, u0 = up_n, m0 = multi_n;
    sl_cpha = 1'b0;
    pl[0] = 8'h20; pl[1] = 8'd2; pl[2] = 8'd0; pl[3] = 8'hA5; pl[4] = 8'h3C;
    send_cmd(8'h11, 16'd5, 5);
    checks++; if (cmd_ready !== 1'b0 || busy !== 1'b1) begin failures++; $display("FAIL wr_active ready=%b busy=%b want 0 1", cmd_ready, busy); end
    wait_idle("wr_done");
    checks++; if (pos_cnt - p0 != 16) begin failures++; $display("FAIL wr_edges got=%0d want 16", pos_cnt - p0); end
    checks++; if (mosi_sh[15:0] !== 16'hA53C) begin failures++; $display("FAIL wr_mosi got=%h want a53c", mosi_sh[15:0]); end
    checks++; if (cs_pat !== 4'b1011) begin failures++; $display("FAIL wr_cs got=%b want 1011", cs_pat); end
    checks++; if (up_n != u0) begin failures++; $display("FAIL wr_noupload got=%0d want 0", up_n - u0); end
    checks++; if (multi_n != m0) begin failures++; $display("FAIL wr_onehot got=%0d want 0", multi_n - m0); end
  endtask

  task automatic test_read();
    int p0 = pos_cnt, u0 = up_n;
    upload_ready = 1'b1; sl_cpha = 1'b0;
    sl_bytes[0] = 8'h55; sl_bytes[1] = 8'hEF; sl_bytes[2] = 8'h40; sl_bytes[3] = 8'h18;
    pl[0] = 8'h00; pl[1] = 8'd1; pl[2] = 8'd3; pl[3] = 8'h9F;
    send_cmd(8'h12, 16'd4, 4);
    wait_idle("rd_done");
    @(negedge clk);
    checks++; if (pos_cnt - p0 != 32) begin failures++; $display("FAIL rd_edges got=%0d want 32", pos_cnt - p0); end
    checks++; if (mosi_sh[31:0] !== 32'h9F000000) begin failures++; $display("FAIL rd_mosi got=%h want 9f000000", mosi_sh[31:0]); end
    checks++; if (cs_pat !== 4'b1110) begin failures++; $display("FAIL rd_cs got=%b want 1110", cs_pat); end
    checks++;
    if (up_n - u0 != 3) begin failures++; $display("FAIL rd_count got=%0d want 3", up_n - u0); end
    else begin
      checks++; if ({up_data[u0], up_data[u0+1], up_data[u0+2]} !== 24'hEF4018) begin failures++; $display("FAIL rd_data got=%h%h%h want ef4018", up_data[u0], up_data[u0+1], up_data[u0+2]); end
      checks++; if ({up_src[u0], up_src[u0+1], up_src[u0+2]} !== 24'h030303) begin failures++; $display("FAIL rd_src got=%h%h%h want 030303", up_src[u0], up_src[u0+1], up_src[u0+2]); end
      checks++; if (up_req_at[u0+2] !== 1'b1 || req_after !== 1'b0) begin failures++; $display("FAIL rd_req at_last=%b after=%b want 1 0", up_req_at[u0+2], req_after); end
    end
  endtask

  task automatic test_type11_forces_no_read();
    int p0 = pos_cnt, u0 = up_n;
    pl[0] = 8'h10; pl[1] = 8'd1; pl[2] = 8'd2; pl[3] = 8'h5A;
    send_cmd(8'h11, 16'd4, 4);
    wait_idle("t11_done");
    checks++; if (pos_cnt - p0 != 8) begin failures++; $display("FAIL t11_edges got=%0d want 8", pos_cnt - p0); end
    checks++; if (mosi_sh[7:0] !== 8'h5A) begin failures++; $display("FAIL t11_mosi got=%h want 5a", mosi_sh[7:0]); end
    checks++; if (up_n != u0) begin failures++; $display("FAIL t11_noupload got=%0d want 0", up_n - u0); end
  endtask

  task automatic do_reject(input string name, input logic [7:0] typ, input logic [15:0] len,
                           input logic [7:0] b0, input logic [7:0] wl, input logic [7:0] rl);
    int t0 = tog_cnt, c0 = cs_cyc, n = 0;
    pl[0] = b0; pl[1] = wl; pl[2] = rl; pl[3] = 8'h77; pl[4] = 8'h66;
    send_cmd(typ, len, 5);
    while (busy && n < 3) begin @(negedge clk); n++; end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL %s_idle busy=%b ready=%b want 0 1", name, busy, cmd_ready); end
    repeat (20) @(negedge clk);
    checks++; if (cs_cyc != c0 || tog_cnt != t0) begin failures++; $display("FAIL %s_quiet cs_cycles=%0d sclk_toggles=%0d want 0 0", name, cs_cyc - c0, tog_cnt - t0); end
  endtask

  task automatic test_reject();
    do_reject("rej_cs", 8'h11, 16'd5, 8'h40, 8'd2, 8'd0);
    do_reject("rej_len", 8'h11, 16'd5, 8'h00, 8'd3, 8'd0);
    do_reject("rej_zero", 8'h12, 16'd5, 8'h00, 8'd0, 8'd0);
    do_reject("rej_type", 8'h13, 16'd5, 8'h00, 8'd1, 8'd0);
  endtask

  task automatic test_upload_stall();
    int u0 = up_n, n = 0;
    upload_ready = 1'b0; sl_cpha = 1'b0;
    sl_bytes[0] = 8'h11; sl_bytes[1] = 8'h22; sl_bytes[2] = 8'h33;
    pl[0] = 8'h30; pl[1] = 8'd0; pl[2] = 8'd3;
    send_cmd(8'h12, 16'd3, 3);
    while (!upload_req && n < 3000) begin @(negedge clk); n++; end
    checks++; if (upload_req !== 1'b1) begin failures++; $display("FAIL st_req timeout: req=%b want 1", upload_req); end
    upload_ready = 1'b1;
    @(negedge clk);
    upload_ready = 1'b0;
    repeat (10) @(negedge clk);
    checks++; if (up_n - u0 != 1 || upload_req !== 1'b1) begin failures++; $display("FAIL st_hold count=%0d req=%b want 1 1", up_n - u0, upload_req); end
    upload_ready = 1'b1;
    wait_idle("st_done");
    checks++; if (cs_pat !== 4'b0111) begin failures++; $display("FAIL st_cs got=%b want 0111", cs_pat); end
    checks++;
    if (up_n - u0 != 3) begin failures++; $display("FAIL st_count got=%0d want 3", up_n - u0); end
    else begin
      checks++; if ({up_data[u0], up_data[u0+1], up_data[u0+2]} !== 24'h112233) begin failures++; $display("FAIL st_data got=%h%h%h want 112233", up_data[u0], up_data[u0+1], up_data[u0+2]); end
    end
  endtask

`ifdef SPI_HANDLER_MODE_SEL_EN
  task automatic test_mode3();
    int p0 = pos_cnt, u0 = up_n;
    upload_ready = 1'b1; sl_cpha = 1'b1;
    sl_bytes[0] = 8'hAA; sl_bytes[1] = 8'h96;
    pl[0] = 8'h13; pl[1] = 8'd1; pl[2] = 8'd1; pl[3] = 8'hC3;
    send_cmd(8'h12, 16'd4, 4);
    wait_idle("m3_done");
    checks++; if (spi_clk !== 1'b1) begin failures++; $display("FAIL m3_idle_hi got=%b want 1", spi_clk); end
    checks++; if (pos_cnt - p0 != 16) begin failures++; $display("FAIL m3_edges got=%0d want 16", pos_cnt - p0); end
    checks++; if (mosi_sh[15:0] !== 16'hC300) begin failures++; $display("FAIL m3_mosi got=%h want c300", mosi_sh[15:0]); end
    checks++;
    if (up_n - u0 != 1) begin failures++; $display("FAIL m3_count got=%0d want 1", up_n - u0); end
    else begin
      checks++; if (up_data[u0] !== 8'h96) begin failures++; $display("FAIL m3_data got=%h want 96", up_data[u0]); end
    end
  endtask
`endif

  task automatic test_reset_mid_shift();
    int n = 0;
    sl_cpha = 1'b0;
    pl[0] = 8'h20; pl[1] = 8'd2; pl[2] = 8'd0; pl[3] = 8'hFF; pl[4] = 8'hFF;
    send_cmd(8'h11, 16'd5, 5);
    begin
      int p0 = pos_cnt;
      while (pos_cnt - p0 < 4 && n < 1000) begin @(negedge clk); n++; end
      checks++; if (spi_cs_n !== 4'b1011) begin failures++; $display("FAIL mr_active cs=%b want 1011", spi_cs_n); end
    end
    #2 rst_n = 1'b0;
    #1;
    checks++; if (spi_cs_n !== 4'hF) begin failures++; $display("FAIL mr_cs got=%b want 1111", spi_cs_n); end
    checks++; if (busy !== 1'b0 || cmd_ready !== 1'b1) begin failures++; $display("FAIL mr_state busy=%b ready=%b want 0 1", busy, cmd_ready); end
    checks++; if (spi_clk !== 1'b0 || spi_mosi !== 1'b0) begin failures++; $display("FAIL mr_lines sclk=%b mosi=%b want 0 0", spi_clk, spi_mosi); end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (busy !== 1'b0 || spi_cs_n !== 4'hF) begin failures++; $display("FAIL mr_after busy=%b cs=%b want 0 1111", busy, spi_cs_n); end
  endtask

  initial begin
    for (int i = 0; i < 8; i++) sl_bytes[i] = 8'h00;
    repeat (3) @(negedge clk);
    test_reset();
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    test_write();
    test_read();
    test_type11_forces_no_read();
    test_reject();
    test_upload_stall();
`ifdef SPI_HANDLER_MODE_SEL_EN
    test_mode3();
`endif
    test_reset_mid_shift();
    checks++; if (multi_n != 0) begin failures++; $display("FAIL cs_onehot multi_low_cycles=%0d want 0", multi_n); end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global_timeout reached without finishing");
    $fatal(1, "timeout");
  end
endmodule
